weight_stream_loader: RTL and testbench

WEIGHT_STREAM_LOADER -- requirements
Module: weight_stream_loader

---
 rtl/weight_stream_loader.sv | 126 ++++++++++++
 tb/tb_weight_stream_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_loader.sv
// Weight tensor loader: captures DEPTH beats into a RAM, then replays them
// cyclically through a one-stage registered read feeding a 2-entry output buffer.
module weight_stream_loader #(
  parameter int unsigned PRECISION   = 16,
  parameter int unsigned PARALLELISM = 4,
  parameter int unsigned DEPTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PRECISION-1:0] data_in [PARALLELISM],
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [PRECISION-1:0] data_out [PARALLELISM],
  output logic                 data_out_valid,
  input  logic                 data_out_ready,
  input  logic                 reload,
  output logic                 load_done
);

  localparam int unsigned Width = PRECISION * PARALLELISM;
  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(DEPTH - 1);

  typedef enum logic {StLoad, StServe} state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [1:0]       cnt_pop;
  logic [Width-1:0] mem_q [DEPTH];
  logic [Width-1:0] slot0_q, slot1_q;
  logic [Width-1:0] wr_word;
  logic             accept, pop, issue;

  always_comb begin
    wr_word = '0;
    for (int unsigned j = 0; j < PARALLELISM; j++) begin
      wr_word[PRECISION*j +: PRECISION] = data_in[j];
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < PARALLELISM; j++) begin
      data_out[j] = slot0_q[PRECISION*j +: PRECISION];
    end
  end

  always_comb begin
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q;
    data_in_ready  = (state_q == StLoad);
    load_done      = (state_q == StServe);
    data_out_valid = (cnt_q != 2'd0);
    // A beat handshaked together with reload is dropped.
    accept         = data_in_ready && data_in_valid && !reload;
    pop            = data_out_valid && data_out_ready;
    cnt_pop        = cnt_q - 2'(pop);
    // Only read when the buffer is guaranteed a free slot at the next edge.
    issue          = (state_q == StServe) && (cnt_pop != 2'd2) && !reload;

    case (state_q)
      StLoad: begin
        if (reload) begin
          wr_ptr_d = '0;
        end else if (accept) begin
          if (wr_ptr_q == LastAddr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            state_d  = StServe;
          end else begin
            wr_ptr_d = wr_ptr_q + AddrW'(1);
          end
        end
      end
      StServe: begin
        if (reload) begin
          state_d  = StLoad;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_pop + 2'(issue);
          if (issue) begin
            rd_ptr_d = (rd_ptr_q == LastAddr) ? '0 : rd_ptr_q + AddrW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StLoad;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked solely by cnt_q.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
    if (pop && (cnt_q == 2'd2)) begin
      slot0_q <= slot1_q;
    end
    if (issue) begin
      if (cnt_pop == 2'd0) begin
        slot0_q <= mem_q[rd_ptr_q];
      end else begin
        slot1_q <= mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader with PRECISION=16, PARALLELISM=2, DEPTH=4.
module tb_weight_stream_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din  [2];
  logic        din_valid;
  logic        din_ready;
  logic [15:0] dout [2];
  logic        dout_valid;
  logic        dout_ready;
  logic        reload;
  logic        load_done;

  int checks   = 0;
  int failures = 0;

  weight_stream_loader #(
    .PRECISION  (16),
    .PARALLELISM(2),
    .DEPTH      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (din),
    .data_in_valid (din_valid),
    .data_in_ready (din_ready),
    .data_out      (dout),
    .data_out_valid(dout_valid),
    .data_out_ready(dout_ready),
    .reload        (reload),
    .load_done     (load_done)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [15:0] a, input logic [15:0] b);
    din[0]    = a;
    din[1]    = b;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reload = 1'b0; din_valid = 1'b0; dout_ready = 1'b0;
    din[0] = 16'h0; din[1] = 16'h0;
    step(); step();
    rst = 1'b0;
    checks++;
    if (din_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready: got %b expected 1", din_ready);
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", dout_valid);
    end
    checks++;
    if (load_done !== 1'b0) begin
      failures++; $display("FAIL reset_load_done: got %b expected 0", load_done);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e0, e1;
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_beat(16'(2 * i + 1), 16'(2 * i + 2));
    checks++;
    if (load_done !== 1'b1 || dout_valid !== 1'b0 || din_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_t1: load_done=%b valid=%b ready=%b expected 1 0 0",
               load_done, dout_valid, din_ready);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      e0 = 16'(2 * (k % 4) + 1);
      e1 = 16'(2 * (k % 4) + 2);
      checks++;
      if (dout_valid !== 1'b1 || dout[0] !== e0 || dout[1] !== e1) begin
        failures++;
        $display("FAIL b2b_beat%0d: got v=%b {%0h,%0h} expected v=1 {%0h,%0h}",
                 k, dout_valid, dout[0], dout[1], e0, e1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic       pattern [5];
    int         idx;
    logic [15:0] e0, e1;
    pattern = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive_beat(16'(2 * i + 1), 16'(2 * i + 2));
    step();
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      dout_ready = pattern[c];
      e0 = 16'(2 * idx + 1);
      e1 = 16'(2 * idx + 2);
      checks++;
      if (dout_valid !== 1'b1 || dout[0] !== e0 || dout[1] !== e1) begin
        failures++;
        $display("FAIL bp_cycle%0d: got v=%b {%0h,%0h} expected v=1 {%0h,%0h}",
                 c, dout_valid, dout[0], dout[1], e0, e1);
      end
      if (pattern[c]) idx++;
      step();
    end
    dout_ready = 1'b0;
    checks++;
    if (dout[0] !== 16'd7 || dout[1] !== 16'd8) begin
      failures++;
      $display("FAIL bp_next: got {%0h,%0h} expected {7,8}", dout[0], dout[1]);
    end
  endtask

  task automatic test_gaps();
    logic        vpat [6];
    logic [15:0] exp0 [4];
    logic [15:0] exp1 [4];
    int          n;
    vpat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    exp0 = '{16'h11, 16'h21, 16'h31, 16'h41};
    exp1 = '{16'h12, 16'h22, 16'h32, 16'h42};
    do_reset();
    dout_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (vpat[c]) begin
        drive_beat(exp0[n], exp1[n]);
        n++;
      end else begin
        din[0] = 16'hdead; din[1] = 16'hbeef;
        step();
      end
    end
    checks++;
    if (load_done !== 1'b1) begin
      failures++; $display("FAIL gaps_done: got %b expected 1", load_done);
    end
    // Junk presented in SERVE must be ignored.
    din[0] = 16'hbad0; din[1] = 16'hbad1; din_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (dout_valid !== 1'b1 || dout[0] !== exp0[k % 4] || dout[1] !== exp1[k % 4]) begin
        failures++;
        $display("FAIL gaps_beat%0d: got v=%b {%0h,%0h} expected v=1 {%0h,%0h}",
                 k, dout_valid, dout[0], dout[1], exp0[k % 4], exp1[k % 4]);
      end
    end
    din_valid = 1'b0;
  endtask

  task automatic test_reload_serve();
    reload = 1'b1;
    step();
    reload = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL reload_serve: valid=%b ready=%b done=%b expected 0 1 0",
               dout_valid, din_ready, load_done);
    end
    dout_ready = 1'b1;
    for (int i = 0; i < 4; i++) drive_beat(16'(9 + i), 16'(9 + i));
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (dout_valid !== 1'b1 || dout[0] !== 16'(9 + k % 4) || dout[1] !== 16'(9 + k % 4)) begin
        failures++;
        $display("FAIL reload_new_beat%0d: got v=%b {%0h,%0h} expected v=1 {%0h,%0h}",
                 k, dout_valid, dout[0], dout[1], 9 + k % 4, 9 + k % 4);
      end
    end
  endtask

  task automatic test_reload_coincident();
    do_reset();
    dout_ready = 1'b1;
    for (int i = 0; i < 3; i++) drive_beat(16'(i + 1), 16'(i + 1));
    reload = 1'b1;
    drive_beat(16'd4, 16'd4);
    reload = 1'b0;
    checks++;
    if (load_done !== 1'b0 || din_ready !== 1'b1) begin
      failures++;
      $display("FAIL coincide_state: done=%b ready=%b expected 0 1", load_done, din_ready);
    end
    for (int i = 0; i < 4; i++) drive_beat(16'(i + 5), 16'(i + 5));
    checks++;
    if (load_done !== 1'b1) begin
      failures++; $display("FAIL coincide_done: got %b expected 1", load_done);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (dout_valid !== 1'b1 || dout[0] !== 16'(k + 5) || dout[1] !== 16'(k + 5)) begin
        failures++;
        $display("FAIL coincide_beat%0d: got v=%b {%0h,%0h} expected v=1 {%0h,%0h}",
                 k, dout_valid, dout[0], dout[1], k + 5, k + 5);
      end
    end
  endtask

  task automatic test_reset_serve();
    checks++;
    if (dout_valid !== 1'b1) begin
      failures++; $display("FAIL rst_serve_pre: got valid=%b expected 1", dout_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1 || load_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_serve: valid=%b ready=%b done=%b expected 0 1 0",
               dout_valid, din_ready, load_done);
    end
    step();
    checks++;
    if (load_done !== 1'b0 || dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_serve_hold: done=%b valid=%b expected 0 0", load_done, dout_valid);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_gaps();
    test_reload_serve();
    test_reload_coincident();
    test_reset_serve();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
